atm_multi_acct_ctrl: RTL and testbench
======================================

// Module: atm_multi_acct_ctrl
// PURPOSE
//  Parametrised multi-account ATM transaction engine; successor of the fixed 10-account ATM core.
//  Holds per-account PIN, balance and failed-attempt counter. Serves one request at a time over a
//  valid/ready request channel and returns a status code plus balance on a valid/ready response
//  channel. Adds PIN lockout, deposit-overflow detection and admin provisioning.
// PARAMETERS
//  N_ACCTS    10     number of accounts; account numbers are 1..N_ACCTS (1-based)
//  ACC_W      4      account-number width; must satisfy 2**ACC_W > N_ACCTS
//  PIN_W      14     PIN width (covers 0..9999)
//  BAL_W      32     balance width, unsigned
//  AMT_W      16     transaction amount width, unsigned, AMT_W <= BAL_W
//  MAX_TRIES  3      consecutive bad PINs before the account locks
//  INIT_BAL   0      balance of every account after reset
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  req_valid   in   1      request present
//  req_ready   out  1      engine idle; request accepted when req_valid&&req_ready at posedge
//  req_op      in   3      1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN, 5 PROVISION; others BAD_OP
//  req_acc     in   ACC_W  account number
//  req_pin     in   PIN_W  entered PIN
//  req_newpin  in   PIN_W  new PIN (CHANGE_PIN, PROVISION)
//  req_amount  in   AMT_W  amount (WITHDRAW, DEPOSIT); PROVISION balance, zero-extended
//  admin_en    in   1      qualifies PROVISION; ignored by every other op
//  day_clr     in   1      clear daily-withdraw totals (used only with ATM_DAILY_LIMIT_EN)
//  rsp_valid   out  1      response present; held until taken
//  rsp_ready   in   1      consumer takes response
//  rsp_code    out  4      0 OK,1 NO_ACCT,2 BAD_PIN,3 LOCKED,4 INSUFF,5 OVERFLOW,6 SAME_PIN,7 BAD_OP,8 LIMIT
//  rsp_balance out  BAL_W  account balance after the op; 0 when rsp_code is NO_ACCT/BAD_OP
//  rsp_success out  1      rsp_code==OK
//  state       out  2      FSM state, debug
// BEHAVIOUR
//  Reset: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_code=0, rsp_balance=0, rsp_success=0.
//   Every account: pin=0, balance=INIT_BAL, fail_cnt=0, daily total=0.
//  FSM IDLE(0)->AUTH(1)->EXEC(2)->RESP(3)->IDLE. req_ready=1 only in IDLE.
//   Accept at edge T; request fields are registered at T. AUTH at T+1. EXEC commits the array
//   update at T+2. rsp_valid=1 from T+2; leaves RESP on the edge where rsp_valid&&rsp_ready.
//   Back-to-back requests: at most one every 4 cycles. Inputs are ignored outside IDLE.
//  AUTH checks run in priority order, first failure wins:
//   BAD_OP > NO_ACCT (acc==0 or acc>N_ACCTS) > LOCKED (fail_cnt==MAX_TRIES) > BAD_PIN.
//   PROVISION with admin_en=1 skips LOCKED and PIN checks. PROVISION with admin_en=0 gives BAD_OP.
//  BAD_PIN increments fail_cnt, which saturates at MAX_TRIES. A correct PIN clears fail_cnt.
//   A locked account reports LOCKED even when the PIN is correct.
//  EXEC, on a passed AUTH:
//   BALANCE: no change.
//   WITHDRAW: amount>balance -> INSUFF, no change; else balance-=amount (amount==0 -> OK).
//   DEPOSIT: balance+amount computed at BAL_W+1 bits; carry -> OVERFLOW, no change; else commit.
//   CHANGE_PIN: newpin==pin -> SAME_PIN, no change; else pin<=newpin.
//   PROVISION: pin<=newpin, balance<=amount, fail_cnt<=0.
//  Failed ops never modify any account.
//  rst mid-transaction: aborts immediately; all state returns to reset values; no partial commit.
// CONFIGURATION
//  `ATM_DAILY_LIMIT_EN defined: adds parameter DAILY_LIMIT (default 5000) and a per-account BAL_W
//   daily total. WITHDRAW fails with LIMIT when total+amount>DAILY_LIMIT. INSUFF is checked first.
//   A successful WITHDRAW adds amount to the daily total. day_clr=1 at a posedge zeroes all totals;
//   if a WITHDRAW commits on that same edge, the clear wins.
//  Undefined: no totals are kept, code LIMIT is never produced, day_clr is ignored.
// STRUCTURE
//  atm_pkg: op and rsp_code localparams, FSM state encodings, code width constant.
//  Sub-module atm_acct_store: PIN/balance/fail_cnt(/daily) arrays. It has one read port (index)
//   and one write port (EXEC). The top holds the FSM, request/response registers and arithmetic.
// TESTING
//  1 Reset with rst=1 mid-RESP -> rsp_valid=0, req_ready=1 next cycle; a BALANCE on acc 1 returns INIT_BAL.
//  2 PROVISION acc3 pin=3456 amt=1000 admin_en=1; DEPOSIT 500 -> OK bal 1500; WITHDRAW 2000 -> INSUFF bal 1500.
//  3 Three BAL requests to acc3 with pin 1111 -> BAD_PIN x3; then pin 3456 -> LOCKED; PROVISION -> OK, unlocked.
//  4 acc=0 and acc=N_ACCTS+1 -> NO_ACCT, rsp_balance=0; op=6 -> BAD_OP; PROVISION admin_en=0 -> BAD_OP.
//  5 BAL_W=16 build: balance 65000, DEPOSIT 600 -> OVERFLOW, balance stays 65000; CHANGE_PIN to same -> SAME_PIN.
//  6 Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_code stable, req_ready=0 throughout.
//    With ATM_DAILY_LIMIT_EN: WITHDRAW 3000 then 2500 -> LIMIT; day_clr pulse; 2500 -> OK.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the multi-account ATM engine.
//  - request opcodes and response status codes
//  - FSM state encoding (also visible on the debug state port)
//  - helper that recognises a legal opcode
package atm_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned CODE_W = 4;

  localparam logic [OP_W-1:0] OP_BALANCE    = 3'd1;
  localparam logic [OP_W-1:0] OP_WITHDRAW   = 3'd2;
  localparam logic [OP_W-1:0] OP_DEPOSIT    = 3'd3;
  localparam logic [OP_W-1:0] OP_CHANGE_PIN = 3'd4;
  localparam logic [OP_W-1:0] OP_PROVISION  = 3'd5;

  localparam logic [CODE_W-1:0] RC_OK       = 4'd0;
  localparam logic [CODE_W-1:0] RC_NO_ACCT  = 4'd1;
  localparam logic [CODE_W-1:0] RC_BAD_PIN  = 4'd2;
  localparam logic [CODE_W-1:0] RC_LOCKED   = 4'd3;
  localparam logic [CODE_W-1:0] RC_INSUFF   = 4'd4;
  localparam logic [CODE_W-1:0] RC_OVERFLOW = 4'd5;
  localparam logic [CODE_W-1:0] RC_SAME_PIN = 4'd6;
  localparam logic [CODE_W-1:0] RC_BAD_OP   = 4'd7;
  localparam logic [CODE_W-1:0] RC_LIMIT    = 4'd8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAuth = 2'd1,
    StExec = 2'd2,
    StResp = 2'd3
  } atm_state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op >= OP_BALANCE) && (op <= OP_PROVISION);
  endfunction

endpackage

// File: rtl/atm_acct_store.sv
// Per-account storage for the ATM engine: PIN, balance, failed-attempt counter and,
// when ATM_DAILY_LIMIT_EN is defined, the daily withdrawn total.
// One combinational read port (rd_idx) and one synchronous write port that rewrites a
// whole account record. Indices are 0-based here; the top maps account numbers.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  rd_idx              read index; rd_pin/rd_bal/rd_fail(/rd_daily) are its record
//  we, wr_idx, wr_*    record write, committed at the rising edge
//  day_clr             (ATM_DAILY_LIMIT_EN only) zero every daily total; beats a write
module atm_acct_store
  import atm_pkg::*;
#(
  parameter int unsigned N_ACCTS  = 10,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned PIN_W    = 14,
  parameter int unsigned BAL_W    = 32,
  parameter int unsigned FAIL_W   = 2,
  parameter int unsigned INIT_BAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [PIN_W-1:0]  rd_pin,
  output logic [BAL_W-1:0]  rd_bal,
  output logic [FAIL_W-1:0] rd_fail,
`ifdef ATM_DAILY_LIMIT_EN
  output logic [BAL_W-1:0]  rd_daily,
  input  logic [BAL_W-1:0]  wr_daily,
  input  logic              day_clr,
`endif
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [PIN_W-1:0]  wr_pin,
  input  logic [BAL_W-1:0]  wr_bal,
  input  logic [FAIL_W-1:0] wr_fail
);

  logic [PIN_W-1:0]  pin_q  [N_ACCTS];
  logic [PIN_W-1:0]  pin_d  [N_ACCTS];
  logic [BAL_W-1:0]  bal_q  [N_ACCTS];
  logic [BAL_W-1:0]  bal_d  [N_ACCTS];
  logic [FAIL_W-1:0] fail_q [N_ACCTS];
  logic [FAIL_W-1:0] fail_d [N_ACCTS];

  assign rd_pin  = pin_q[rd_idx];
  assign rd_bal  = bal_q[rd_idx];
  assign rd_fail = fail_q[rd_idx];

  always_comb begin
    pin_d  = pin_q;
    bal_d  = bal_q;
    fail_d = fail_q;
    if (we) begin
      pin_d[wr_idx]  = wr_pin;
      bal_d[wr_idx]  = wr_bal;
      fail_d[wr_idx] = wr_fail;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ACCTS); i++) begin
        pin_q[i]  <= '0;
        bal_q[i]  <= BAL_W'(INIT_BAL);
        fail_q[i] <= '0;
      end
    end else begin
      pin_q  <= pin_d;
      bal_q  <= bal_d;
      fail_q <= fail_d;
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  logic [BAL_W-1:0] daily_q [N_ACCTS];
  logic [BAL_W-1:0] daily_d [N_ACCTS];

  assign rd_daily = daily_q[rd_idx];

  always_comb begin
    daily_d = daily_q;
    if (we) daily_d[wr_idx] = wr_daily;
    // A clear on the same edge as a committing withdraw wins.
    if (day_clr) begin
      for (int i = 0; i < int'(N_ACCTS); i++) daily_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ACCTS); i++) daily_q[i] <= '0;
    end else begin
      daily_q <= daily_d;
    end
  end
`endif

endmodule

// File: rtl/atm_multi_acct_ctrl.sv
// Multi-account ATM transaction engine. One request at a time:
//  IDLE (accept, register fields) -> AUTH (op/account/lock/PIN checks) ->
//  EXEC (arithmetic, commit to the account store, register response) -> RESP (hold
//  until rsp_ready). Optional daily withdraw limit under `ATM_DAILY_LIMIT_EN.
// Ports:
//  clk, rst                     clock, asynchronous active-high reset
//  req_valid/req_ready          request handshake (ready only in IDLE)
//  req_op/acc/pin/newpin/amount request fields; admin_en qualifies PROVISION
//  day_clr                      clear daily totals (limit build only)
//  rsp_valid/rsp_ready          response handshake; response held until taken
//  rsp_code/balance/success     status, balance after the op, code==OK
//  state                        FSM state for debug
module atm_multi_acct_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned N_ACCTS   = 10,
  parameter int unsigned ACC_W     = 4,
  parameter int unsigned PIN_W     = 14,
  parameter int unsigned BAL_W     = 32,
  parameter int unsigned AMT_W     = 16,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned INIT_BAL  = 0
`ifdef ATM_DAILY_LIMIT_EN
  ,
  parameter int unsigned DAILY_LIMIT = 5000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ACC_W-1:0]  req_acc,
  input  logic [PIN_W-1:0]  req_pin,
  input  logic [PIN_W-1:0]  req_newpin,
  input  logic [AMT_W-1:0]  req_amount,
  input  logic              admin_en,
  input  logic              day_clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CODE_W-1:0] rsp_code,
  output logic [BAL_W-1:0]  rsp_balance,
  output logic              rsp_success,
  output logic [1:0]        state
);

  localparam int unsigned IDX_W  = (N_ACCTS > 1) ? $clog2(N_ACCTS) : 1;
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam logic [ACC_W-1:0]  NAcc    = ACC_W'(N_ACCTS);
  localparam logic [FAIL_W-1:0] MaxFail = FAIL_W'(MAX_TRIES);

  atm_state_e state_q, state_d;

  logic [OP_W-1:0]   op_q, op_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [PIN_W-1:0]  newpin_q, newpin_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic              admin_q, admin_d;
  logic [CODE_W-1:0] auth_code_q, auth_code_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [CODE_W-1:0] rsp_code_q, rsp_code_d;
  logic [BAL_W-1:0]  rsp_bal_q, rsp_bal_d;
  logic              rsp_success_q, rsp_success_d;

  // Store interface
  logic              acc_ok;
  logic [IDX_W-1:0]  idx;
  logic [PIN_W-1:0]  rd_pin;
  logic [BAL_W-1:0]  rd_bal;
  logic [FAIL_W-1:0] rd_fail;
  logic              we;
  logic [PIN_W-1:0]  wr_pin;
  logic [BAL_W-1:0]  wr_bal;
  logic [FAIL_W-1:0] wr_fail;

  logic [BAL_W-1:0]  amt_ext;
  logic [BAL_W:0]    dep_sum;
  logic [CODE_W-1:0] exec_code;

`ifdef ATM_DAILY_LIMIT_EN
  logic [BAL_W-1:0]  rd_daily;
  logic [BAL_W-1:0]  wr_daily;
  logic [BAL_W:0]    daily_sum;
  assign daily_sum = {1'b0, rd_daily} + (BAL_W + 1)'(amt_q);
`else
  logic unused_day_clr;
  assign unused_day_clr = day_clr;
`endif

  assign acc_ok  = (acc_q != '0) && (acc_q <= NAcc);
  // Out-of-range accounts read entry 0; their results never depend on it.
  assign idx     = acc_ok ? IDX_W'(acc_q - ACC_W'(1)) : '0;
  assign amt_ext = BAL_W'(amt_q);
  assign dep_sum = {1'b0, rd_bal} + (BAL_W + 1)'(amt_q);

  atm_acct_store #(
    .N_ACCTS  (N_ACCTS),
    .IDX_W    (IDX_W),
    .PIN_W    (PIN_W),
    .BAL_W    (BAL_W),
    .FAIL_W   (FAIL_W),
    .INIT_BAL (INIT_BAL)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_pin   (rd_pin),
    .rd_bal   (rd_bal),
    .rd_fail  (rd_fail),
`ifdef ATM_DAILY_LIMIT_EN
    .rd_daily (rd_daily),
    .wr_daily (wr_daily),
    .day_clr  (day_clr),
`endif
    .we       (we),
    .wr_idx   (idx),
    .wr_pin   (wr_pin),
    .wr_bal   (wr_bal),
    .wr_fail  (wr_fail)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    acc_d         = acc_q;
    pin_d         = pin_q;
    newpin_d      = newpin_q;
    amt_d         = amt_q;
    admin_d       = admin_q;
    auth_code_d   = auth_code_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_code_d    = rsp_code_q;
    rsp_bal_d     = rsp_bal_q;
    rsp_success_d = rsp_success_q;
    we            = 1'b0;
    wr_pin        = rd_pin;
    wr_bal        = rd_bal;
    wr_fail       = rd_fail;
    exec_code     = auth_code_q;
`ifdef ATM_DAILY_LIMIT_EN
    wr_daily      = rd_daily;
`endif

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = req_op;
          acc_d    = req_acc;
          pin_d    = req_pin;
          newpin_d = req_newpin;
          amt_d    = req_amount;
          admin_d  = admin_en;
          state_d  = StAuth;
        end
      end

      StAuth: begin
        if (!op_is_legal(op_q) || ((op_q == OP_PROVISION) && !admin_q)) begin
          auth_code_d = RC_BAD_OP;
        end else if (!acc_ok) begin
          auth_code_d = RC_NO_ACCT;
        end else if (op_q == OP_PROVISION) begin
          auth_code_d = RC_OK;  // admin provisioning bypasses lock and PIN
        end else if (rd_fail == MaxFail) begin
          auth_code_d = RC_LOCKED;
        end else if (rd_pin != pin_q) begin
          auth_code_d = RC_BAD_PIN;
        end else begin
          auth_code_d = RC_OK;
        end
        state_d = StExec;
      end

      StExec: begin
        rsp_bal_d = rd_bal;
        case (auth_code_q)
          RC_OK: begin
            we      = 1'b1;
            // A passed PIN check clears the counter even if the op itself then fails.
            wr_fail = '0;
            case (op_q)
              OP_WITHDRAW: begin
                if (amt_ext > rd_bal) begin
                  exec_code = RC_INSUFF;
`ifdef ATM_DAILY_LIMIT_EN
                end else if (daily_sum > (BAL_W + 1)'(DAILY_LIMIT)) begin
                  exec_code = RC_LIMIT;
`endif
                end else begin
                  wr_bal   = rd_bal - amt_ext;
`ifdef ATM_DAILY_LIMIT_EN
                  wr_daily = daily_sum[BAL_W-1:0];
`endif
                end
              end
              OP_DEPOSIT: begin
                if (dep_sum[BAL_W]) exec_code = RC_OVERFLOW;
                else                wr_bal    = dep_sum[BAL_W-1:0];
              end
              OP_CHANGE_PIN: begin
                if (newpin_q == rd_pin) exec_code = RC_SAME_PIN;
                else                    wr_pin    = newpin_q;
              end
              OP_PROVISION: begin
                wr_pin = newpin_q;
                wr_bal = amt_ext;
              end
              default: ;  // BALANCE: read only
            endcase
            rsp_bal_d = wr_bal;
          end
          RC_BAD_PIN: begin
            we      = 1'b1;
            wr_fail = (rd_fail == MaxFail) ? rd_fail : rd_fail + FAIL_W'(1);
          end
          RC_NO_ACCT, RC_BAD_OP: rsp_bal_d = '0;
          default: ;  // LOCKED: report balance, no change
        endcase
        rsp_code_d    = exec_code;
        rsp_success_d = (exec_code == RC_OK);
        rsp_valid_d   = 1'b1;
        state_d       = StResp;
      end

      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      acc_q         <= '0;
      pin_q         <= '0;
      newpin_q      <= '0;
      amt_q         <= '0;
      admin_q       <= 1'b0;
      auth_code_q   <= RC_OK;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= RC_OK;
      rsp_bal_q     <= '0;
      rsp_success_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      acc_q         <= acc_d;
      pin_q         <= pin_d;
      newpin_q      <= newpin_d;
      amt_q         <= amt_d;
      admin_q       <= admin_d;
      auth_code_q   <= auth_code_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_code_q    <= rsp_code_d;
      rsp_bal_q     <= rsp_bal_d;
      rsp_success_q <= rsp_success_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_balance = rsp_bal_q;
  assign rsp_success = rsp_success_q;
  assign state       = state_q;

endmodule

// File: tb/tb_atm_multi_acct_ctrl.sv
// Bench for atm_multi_acct_ctrl, built with BAL_W=16 so deposit overflow is reachable
// and INIT_BAL=100 so reset values are distinguishable from zero.
module tb_atm_multi_acct_ctrl;
  localparam int unsigned BW   = 16;
  localparam int unsigned INIT = 100;

  logic          clk, rst;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [3:0]    req_acc;
  logic [13:0]   req_pin, req_newpin;
  logic [15:0]   req_amount;
  logic          admin_en, day_clr;
  logic          rsp_valid, rsp_ready;
  logic [3:0]    rsp_code;
  logic [BW-1:0] rsp_balance;
  logic          rsp_success;
  logic [1:0]    state;

  atm_multi_acct_ctrl #(
    .BAL_W    (BW),
    .INIT_BAL (INIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_acc     (req_acc),
    .req_pin     (req_pin),
    .req_newpin  (req_newpin),
    .req_amount  (req_amount),
    .admin_en    (admin_en),
    .day_clr     (day_clr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_code    (rsp_code),
    .rsp_balance (rsp_balance),
    .rsp_success (rsp_success),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  acc;
    logic [13:0] pin;
    logic [13:0] newpin;
    logic [15:0] amt;
    logic        admin;
    logic [3:0]  code;
    logic [15:0] bal;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] acc,
                              input logic [13:0] pin, input logic [13:0] newpin,
                              input logic [15:0] amt, input logic admin,
                              input logic [3:0] code, input logic [15:0] bal);
    vec_t v;
    v.op = op; v.acc = acc; v.pin = pin; v.newpin = newpin;
    v.amt = amt; v.admin = admin; v.code = code; v.bal = bal;
    return v;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [3:0] acc, input logic [13:0] pin,
                       input logic [13:0] newpin, input logic [15:0] amt, input logic admin);
    int n;
    @(negedge clk);
    req_op = op; req_acc = acc; req_pin = pin; req_newpin = newpin;
    req_amount = amt; admin_en = admin; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    if (!rsp_valid) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [3:0] acc, input logic [13:0] pin,
                     input logic [13:0] newpin, input logic [15:0] amt, input logic admin,
                     output logic [3:0] code, output logic [15:0] bal, output logic ok,
                     output int lat);
    issue(op, acc, pin, newpin, amt, admin);
    wait_rsp(lat);
    code = rsp_code;
    bal  = rsp_balance;
    ok   = rsp_success;
    take();
  endtask

  task automatic run_chk(input string name, input logic [2:0] op, input logic [3:0] acc,
                         input logic [13:0] pin, input logic [15:0] amt,
                         input logic [3:0] ecode, input logic [15:0] ebal);
    logic [3:0] c; logic [15:0] b; logic s; int l;
    run(op, acc, pin, 14'd0, amt, 1'b0, c, b, s, l);
    check({name, "_code"}, {28'd0, c}, {28'd0, ecode});
    check({name, "_bal"}, {16'd0, b}, {16'd0, ebal});
  endtask

  initial begin
    logic [3:0]  c;
    logic [15:0] b;
    logic        s;
    int          lat;
    logic [3:0]  held_code;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; day_clr = 1'b0;
    req_op = '0; req_acc = '0; req_pin = '0; req_newpin = '0; req_amount = '0;
    admin_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_code", {28'd0, rsp_code}, 32'd0);
    check("rst_rsp_bal", {16'd0, rsp_balance}, 32'd0);
    check("rst_rsp_success", {31'd0, rsp_success}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    rst = 1'b0;

    // op acc pin newpin amt admin -> code bal
    vecs.push_back(mk(3'd1, 4'd1, 14'd0, 14'd0, 16'd0, 1'b0, 4'd0, 16'd100));
    vecs.push_back(mk(3'd5, 4'd3, 14'd9, 14'd3456, 16'd1000, 1'b1, 4'd0, 16'd1000));
    vecs.push_back(mk(3'd3, 4'd3, 14'd3456, 14'd0, 16'd500, 1'b0, 4'd0, 16'd1500));
    vecs.push_back(mk(3'd2, 4'd3, 14'd3456, 14'd0, 16'd2000, 1'b0, 4'd4, 16'd1500));
    vecs.push_back(mk(3'd2, 4'd3, 14'd3456, 14'd0, 16'd200, 1'b0, 4'd0, 16'd1300));
    vecs.push_back(mk(3'd2, 4'd3, 14'd3456, 14'd0, 16'd0, 1'b0, 4'd0, 16'd1300));
    vecs.push_back(mk(3'd1, 4'd3, 14'd1111, 14'd0, 16'd0, 1'b0, 4'd2, 16'd1300));
    vecs.push_back(mk(3'd1, 4'd3, 14'd1111, 14'd0, 16'd0, 1'b0, 4'd2, 16'd1300));
    vecs.push_back(mk(3'd1, 4'd3, 14'd1111, 14'd0, 16'd0, 1'b0, 4'd2, 16'd1300));
    vecs.push_back(mk(3'd1, 4'd3, 14'd3456, 14'd0, 16'd0, 1'b0, 4'd3, 16'd1300));
    vecs.push_back(mk(3'd5, 4'd3, 14'd0, 14'd3456, 16'd1300, 1'b1, 4'd0, 16'd1300));
    vecs.push_back(mk(3'd1, 4'd3, 14'd3456, 14'd0, 16'd0, 1'b0, 4'd0, 16'd1300));
    vecs.push_back(mk(3'd1, 4'd0, 14'd0, 14'd0, 16'd0, 1'b0, 4'd1, 16'd0));
    vecs.push_back(mk(3'd1, 4'd11, 14'd0, 14'd0, 16'd0, 1'b0, 4'd1, 16'd0));
    vecs.push_back(mk(3'd6, 4'd3, 14'd3456, 14'd0, 16'd0, 1'b0, 4'd7, 16'd0));
    vecs.push_back(mk(3'd5, 4'd3, 14'd3456, 14'd1, 16'd5, 1'b0, 4'd7, 16'd0));
    vecs.push_back(mk(3'd0, 4'd3, 14'd3456, 14'd0, 16'd0, 1'b0, 4'd7, 16'd0));
    vecs.push_back(mk(3'd5, 4'd5, 14'd0, 14'd42, 16'd65000, 1'b1, 4'd0, 16'd65000));
    vecs.push_back(mk(3'd3, 4'd5, 14'd42, 14'd0, 16'd600, 1'b0, 4'd5, 16'd65000));
    vecs.push_back(mk(3'd3, 4'd5, 14'd42, 14'd0, 16'd535, 1'b0, 4'd0, 16'd65535));
    vecs.push_back(mk(3'd4, 4'd5, 14'd42, 14'd42, 16'd0, 1'b0, 4'd6, 16'd65535));
    vecs.push_back(mk(3'd4, 4'd5, 14'd42, 14'd77, 16'd0, 1'b0, 4'd0, 16'd65535));
    vecs.push_back(mk(3'd1, 4'd5, 14'd42, 14'd0, 16'd0, 1'b0, 4'd2, 16'd65535));
    vecs.push_back(mk(3'd1, 4'd5, 14'd77, 14'd0, 16'd0, 1'b0, 4'd0, 16'd65535));
    vecs.push_back(mk(3'd1, 4'd10, 14'd0, 14'd0, 16'd0, 1'b0, 4'd0, 16'd100));
    // Correct PIN resets the counter: 2 bad, good, 2 bad, good stays unlocked
    vecs.push_back(mk(3'd1, 4'd2, 14'd9, 14'd0, 16'd0, 1'b0, 4'd2, 16'd100));
    vecs.push_back(mk(3'd1, 4'd2, 14'd9, 14'd0, 16'd0, 1'b0, 4'd2, 16'd100));
    vecs.push_back(mk(3'd1, 4'd2, 14'd0, 14'd0, 16'd0, 1'b0, 4'd0, 16'd100));
    vecs.push_back(mk(3'd1, 4'd2, 14'd9, 14'd0, 16'd0, 1'b0, 4'd2, 16'd100));
    vecs.push_back(mk(3'd1, 4'd2, 14'd9, 14'd0, 16'd0, 1'b0, 4'd2, 16'd100));
    vecs.push_back(mk(3'd1, 4'd2, 14'd0, 14'd0, 16'd0, 1'b0, 4'd0, 16'd100));
    // Lockout saturates; locked withdraw changes nothing; provision unlocks
    vecs.push_back(mk(3'd1, 4'd4, 14'd1, 14'd0, 16'd0, 1'b0, 4'd2, 16'd100));
    vecs.push_back(mk(3'd1, 4'd4, 14'd1, 14'd0, 16'd0, 1'b0, 4'd2, 16'd100));
    vecs.push_back(mk(3'd1, 4'd4, 14'd1, 14'd0, 16'd0, 1'b0, 4'd2, 16'd100));
    vecs.push_back(mk(3'd1, 4'd4, 14'd1, 14'd0, 16'd0, 1'b0, 4'd3, 16'd100));
    vecs.push_back(mk(3'd1, 4'd4, 14'd0, 14'd0, 16'd0, 1'b0, 4'd3, 16'd100));
    vecs.push_back(mk(3'd2, 4'd4, 14'd0, 14'd0, 16'd50, 1'b0, 4'd3, 16'd100));
    vecs.push_back(mk(3'd5, 4'd4, 14'd0, 14'd0, 16'd100, 1'b1, 4'd0, 16'd100));
    vecs.push_back(mk(3'd2, 4'd4, 14'd0, 14'd0, 16'd50, 1'b0, 4'd0, 16'd50));

    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].acc, vecs[i].pin, vecs[i].newpin, vecs[i].amt, vecs[i].admin,
          c, b, s, lat);
      if (i == 0) check("latency", lat, 32'd3);
      check($sformatf("vec%0d_code", i), {28'd0, c}, {28'd0, vecs[i].code});
      check($sformatf("vec%0d_bal", i), {16'd0, b}, {16'd0, vecs[i].bal});
      check($sformatf("vec%0d_success", i), {31'd0, s}, {31'd0, vecs[i].code == 4'd0});
    end

    // Response held under backpressure; a new request meanwhile is ignored
    issue(3'd1, 4'd3, 14'd3456, 14'd0, 16'd0, 1'b0);
    wait_rsp(lat);
    held_code = rsp_code;
    check("hold_first_code", {28'd0, held_code}, 32'd0);
    req_op = 3'd2; req_acc = 4'd3; req_pin = 14'd3456; req_amount = 16'd10;
    req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("hold%0d_code", k), {28'd0, rsp_code}, 32'd0);
      check($sformatf("hold%0d_ready", k), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    take();
    check("hold_after_state", {30'd0, state}, 32'd0);
    run_chk("hold_no_withdraw", 3'd1, 4'd3, 14'd3456, 16'd0, 4'd0, 16'd1300);

`ifdef ATM_DAILY_LIMIT_EN
    run(3'd5, 4'd6, 14'd0, 14'd6, 16'd10000, 1'b1, c, b, s, lat);
    check("lim_prov_code", {28'd0, c}, 32'd0);
    run_chk("lim_w3000", 3'd2, 4'd6, 14'd6, 16'd3000, 4'd0, 16'd7000);
    run_chk("lim_w2500", 3'd2, 4'd6, 14'd6, 16'd2500, 4'd8, 16'd7000);
    @(negedge clk);
    day_clr = 1'b1;
    @(negedge clk);
    day_clr = 1'b0;
    run_chk("lim_after_clr", 3'd2, 4'd6, 14'd6, 16'd2500, 4'd0, 16'd4500);
`else
    @(negedge clk);
    day_clr = 1'b1;
    @(negedge clk);
    day_clr = 1'b0;
    run_chk("nolim_w3000", 3'd2, 4'd1, 14'd0, 16'd0, 4'd0, 16'd100);
`endif

    // Reset while a response is pending: deposit committed, then wiped by reset
    issue(3'd3, 4'd1, 14'd0, 14'd0, 16'd50, 1'b0);
    wait_rsp(lat);
    check("pre_rst_bal", {16'd0, rsp_balance}, 32'd150);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    run_chk("postrst_acc1", 3'd1, 4'd1, 14'd0, 16'd0, 4'd0, 16'd100);
    run_chk("postrst_acc5_pin", 3'd1, 4'd5, 14'd0, 16'd0, 4'd0, 16'd100);
    run_chk("postrst_acc3_pin", 3'd1, 4'd3, 14'd3456, 16'd0, 4'd2, 16'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
